// File: rtl/tx_arbiter_pkg.sv
// Shared widths, reply-owner encoding and FSM state type for the TX channel arbiter.
package tx_arbiter_pkg;

   localparam int TX_CMD_BITS = 8;

   localparam logic OWNER_PF = 1'b0;
   localparam logic OWNER_SC = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY_PF = 2'd1,
      ST_BUSY_SC = 2'd2
   } arb_state_t;

endpackage

// File: rtl/tx_arbiter_reply_owner_fifo.sv
// 1-bit-wide owner FIFO: records which requester owns each outstanding reply, in issue order.
module tx_arbiter_reply_owner_fifo #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_push,
   input  logic i_push_owner,
   input  logic i_pop,
   output logic o_head,
   output logic o_full,
   output logic o_empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic          r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_do_push;
   logic          w_do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_head    = r_mem[r_rd_ptr];
   // A push into a full FIFO is dropped; the arbiter never issues one.
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_push_owner;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/tx_arbiter.sv
// Shares the serial TX channel between prefetcher and scheduler and steers RX replies to their owner.
//  state      | meaning
//  ST_IDLE    | no transfer; round-robin arbitration presents a command
//  ST_BUSY_PF | prefetch owns the channel until tx_done
//  ST_BUSY_SC | scheduler owns the channel until tx_done
module tx_arbiter
   import tx_arbiter_pkg::*;
#(
   parameter int NSHIFT      = 2,
   parameter int REPLY_DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_pf_cmd_valid,
   input  logic [TX_CMD_BITS-1:0] i_pf_cmd,
   input  logic                   i_pf_reply_wanted,
   output logic                   o_pf_cmd_started,
   input  logic                   i_sc_cmd_valid,
   input  logic [TX_CMD_BITS-1:0] i_sc_cmd,
   input  logic                   i_sc_reply_wanted,
   input  logic                   i_sc_reserve,
   output logic                   o_sc_cmd_started,
   input  logic [NSHIFT-1:0]      i_pf_data,
   input  logic [NSHIFT-1:0]      i_sc_data,
   output logic                   o_pf_data_next,
   output logic                   o_sc_data_next,
   output logic                   o_tx_command_valid,
   output logic [TX_CMD_BITS-1:0] o_tx_command,
   input  logic                   i_tx_command_ready,
   output logic [NSHIFT-1:0]      o_tx_data,
   input  logic                   i_tx_data_next,
   input  logic                   i_tx_done,
   input  logic                   i_rx_done,
   output logic                   o_rx_to_pf,
   output logic                   o_rx_to_sc,
   output logic                   o_reply_full,
   output logic                   o_protocol_error
);

   arb_state_t r_state;
   arb_state_t w_state_nxt;
   logic       r_last_grant;
   logic       r_proto_err;
   logic       w_fifo_head;
   logic       w_fifo_full;
   logic       w_fifo_empty;
   logic       w_pf_elig;
   logic       w_sc_elig;
   logic       w_grant_sc;
   logic       w_accept;
   logic       w_push;

   // Blocking uses the registered full flag, so a same-cycle pop does not unblock.
   assign w_pf_elig  = i_pf_cmd_valid & ~i_sc_reserve & ~(i_pf_reply_wanted & w_fifo_full);
   assign w_sc_elig  = i_sc_cmd_valid & ~(i_sc_reply_wanted & w_fifo_full);
   assign w_grant_sc = w_sc_elig & (~w_pf_elig | (r_last_grant == OWNER_PF));

   always_comb begin
      w_state_nxt        = r_state;
      w_accept           = 1'b0;
      o_tx_command_valid = 1'b0;
      o_tx_command       = '0;
      o_pf_cmd_started   = 1'b0;
      o_sc_cmd_started   = 1'b0;
      o_tx_data          = '0;
      o_pf_data_next     = 1'b0;
      o_sc_data_next     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            o_tx_command_valid = w_pf_elig | w_sc_elig;
            if (o_tx_command_valid)
               o_tx_command = w_grant_sc ? i_sc_cmd : i_pf_cmd;
            w_accept = o_tx_command_valid & i_tx_command_ready;
            if (w_accept) begin
               o_sc_cmd_started = w_grant_sc;
               o_pf_cmd_started = ~w_grant_sc;
               w_state_nxt      = w_grant_sc ? ST_BUSY_SC : ST_BUSY_PF;
            end
         end
         ST_BUSY_PF: begin
            o_tx_data      = i_pf_data;
            o_pf_data_next = i_tx_data_next;
            if (i_tx_done) w_state_nxt = ST_IDLE;
         end
         ST_BUSY_SC: begin
            o_tx_data      = i_sc_data;
            o_sc_data_next = i_tx_data_next;
            if (i_tx_done) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_push = w_accept & (w_grant_sc ? i_sc_reply_wanted : i_pf_reply_wanted);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_last_grant <= OWNER_SC;
         r_proto_err  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) r_last_grant <= w_grant_sc ? OWNER_SC : OWNER_PF;
         if (i_rx_done & w_fifo_empty) r_proto_err <= 1'b1;
      end
   end

   tx_arbiter_reply_owner_fifo #(
      .DEPTH (REPLY_DEPTH)
   ) u_reply_fifo (
      .clk          (clk),
      .reset        (reset),
      .i_push       (w_push),
      .i_push_owner (w_grant_sc),
      .i_pop        (i_rx_done),
      .o_head       (w_fifo_head),
      .o_full       (w_fifo_full),
      .o_empty      (w_fifo_empty)
   );

   assign o_rx_to_pf       = ~w_fifo_empty & (w_fifo_head == OWNER_PF);
   assign o_rx_to_sc       = ~w_fifo_empty & (w_fifo_head == OWNER_SC);
   assign o_reply_full     = w_fifo_full;
   assign o_protocol_error = r_proto_err;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: arbitration, payload routing, reply ownership and error flag.
module tb_tx_arbiter;
   import tx_arbiter_pkg::*;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   pf_cmd_valid, pf_reply_wanted, pf_cmd_started;
   logic [TX_CMD_BITS-1:0] pf_cmd, sc_cmd, tx_command;
   logic                   sc_cmd_valid, sc_reply_wanted, sc_reserve, sc_cmd_started;
   logic [1:0]             pf_data, sc_data, tx_data;
   logic                   pf_data_next, sc_data_next;
   logic                   tx_command_valid, tx_command_ready, tx_data_next;
   logic                   tx_done, rx_done, rx_to_pf, rx_to_sc, reply_full, protocol_error;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tx_arbiter #(.NSHIFT(2), .REPLY_DEPTH(2)) dut (
      .clk                (clk),
      .reset              (reset),
      .i_pf_cmd_valid     (pf_cmd_valid),
      .i_pf_cmd           (pf_cmd),
      .i_pf_reply_wanted  (pf_reply_wanted),
      .o_pf_cmd_started   (pf_cmd_started),
      .i_sc_cmd_valid     (sc_cmd_valid),
      .i_sc_cmd           (sc_cmd),
      .i_sc_reply_wanted  (sc_reply_wanted),
      .i_sc_reserve       (sc_reserve),
      .o_sc_cmd_started   (sc_cmd_started),
      .i_pf_data          (pf_data),
      .i_sc_data          (sc_data),
      .o_pf_data_next     (pf_data_next),
      .o_sc_data_next     (sc_data_next),
      .o_tx_command_valid (tx_command_valid),
      .o_tx_command       (tx_command),
      .i_tx_command_ready (tx_command_ready),
      .o_tx_data          (tx_data),
      .i_tx_data_next     (tx_data_next),
      .i_tx_done          (tx_done),
      .i_rx_done          (rx_done),
      .o_rx_to_pf         (rx_to_pf),
      .o_rx_to_sc         (rx_to_sc),
      .o_reply_full       (reply_full),
      .o_protocol_error   (protocol_error)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      pf_cmd_valid = 0; pf_cmd = '0; pf_reply_wanted = 0;
      sc_cmd_valid = 0; sc_cmd = '0; sc_reply_wanted = 0; sc_reserve = 0;
      pf_data = '0; sc_data = '0;
      tx_command_ready = 0; tx_data_next = 0; tx_done = 0; rx_done = 0;
      step(); step();
      reset = 1'b0;
      step();

      chk("rst_cmd_valid", 32'(tx_command_valid), 0);
      chk("rst_rx_pf", 32'(rx_to_pf), 0);
      chk("rst_rx_sc", 32'(rx_to_sc), 0);
      chk("rst_full", 32'(reply_full), 0);
      chk("rst_perr", 32'(protocol_error), 0);
      chk("rst_tx_data", 32'(tx_data), 0);

      // scheduler only
      sc_cmd_valid = 1; sc_cmd = 8'h05; tx_command_ready = 1; sc_data = 2'b10; pf_data = 2'b01;
      #1;
      chk("sc_only_valid", 32'(tx_command_valid), 1);
      chk("sc_only_cmd", 32'(tx_command), 32'h05);
      chk("sc_only_started", 32'(sc_cmd_started), 1);
      chk("sc_only_pf_started", 32'(pf_cmd_started), 0);
      step();
      sc_cmd_valid = 0; tx_data_next = 1;
      #1;
      chk("busy_sc_valid", 32'(tx_command_valid), 0);
      chk("busy_sc_started", 32'(sc_cmd_started), 0);
      chk("busy_sc_data", 32'(tx_data), 32'h2);
      chk("busy_sc_next", 32'(sc_data_next), 1);
      chk("busy_sc_pf_next", 32'(pf_data_next), 0);
      sc_data = 2'b01;
      #1;
      chk("busy_sc_data2", 32'(tx_data), 32'h1);
      tx_data_next = 0;
      #1;
      chk("busy_sc_next_low", 32'(sc_data_next), 0);
      tx_done = 1; sc_cmd_valid = 1; tx_command_ready = 0;
      #1;
      chk("txdone_no_grant", 32'(tx_command_valid), 0);
      step();
      tx_done = 0;
      #1;
      chk("idle_after_done", 32'(tx_command_valid), 1);
      chk("idle_data_zero", 32'(tx_data), 0);
      sc_cmd_valid = 0;

      // round robin: last grant SC, so PF wins first
      pf_cmd_valid = 1; pf_cmd = 8'hA1; sc_cmd_valid = 1; sc_cmd = 8'hC3; tx_command_ready = 1;
      pf_data = 2'b11; sc_data = 2'b00;
      #1;
      chk("rr1_cmd", 32'(tx_command), 32'hA1);
      chk("rr1_pf_started", 32'(pf_cmd_started), 1);
      chk("rr1_sc_started", 32'(sc_cmd_started), 0);
      step();
      tx_data_next = 1;
      #1;
      chk("rr_busy_pf_data", 32'(tx_data), 32'h3);
      chk("rr_busy_pf_next", 32'(pf_data_next), 1);
      chk("rr_busy_sc_next", 32'(sc_data_next), 0);
      tx_data_next = 0; tx_done = 1;
      step();
      tx_done = 0;
      #1;
      chk("rr2_cmd", 32'(tx_command), 32'hC3);
      chk("rr2_sc_started", 32'(sc_cmd_started), 1);
      chk("rr2_pf_started", 32'(pf_cmd_started), 0);
      step();
      pf_cmd_valid = 0; sc_cmd_valid = 0; tx_done = 1;
      step();
      tx_done = 0;

      // reserve blocks prefetch indefinitely
      sc_reserve = 1; pf_cmd_valid = 1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("reserve_valid", 32'(tx_command_valid), 0);
         chk("reserve_started", 32'(pf_cmd_started), 0);
         step();
      end
      sc_reserve = 0; pf_cmd_valid = 0;
      step();

      // reply tracking: PF reply then SC reply fills the FIFO
      pf_cmd_valid = 1; pf_reply_wanted = 1;
      #1;
      chk("rep_pf_started", 32'(pf_cmd_started), 1);
      step();
      pf_cmd_valid = 0; tx_done = 1;
      step();
      tx_done = 0;
      #1;
      chk("rep1_rx_pf", 32'(rx_to_pf), 1);
      chk("rep1_full", 32'(reply_full), 0);
      sc_cmd_valid = 1; sc_reply_wanted = 1;
      #1;
      chk("rep_sc_started", 32'(sc_cmd_started), 1);
      step();
      sc_cmd_valid = 0; tx_done = 1;
      step();
      tx_done = 0;
      #1;
      chk("rep2_full", 32'(reply_full), 1);
      chk("rep2_rx_pf", 32'(rx_to_pf), 1);
      chk("rep2_rx_sc", 32'(rx_to_sc), 0);
      pf_cmd_valid = 1;
      #1;
      chk("full_block_valid", 32'(tx_command_valid), 0);
      chk("full_block_started", 32'(pf_cmd_started), 0);
      rx_done = 1;
      #1;
      chk("full_pop_block", 32'(tx_command_valid), 0);
      step();
      rx_done = 0; pf_cmd_valid = 0;
      #1;
      chk("pop1_rx_pf", 32'(rx_to_pf), 0);
      chk("pop1_rx_sc", 32'(rx_to_sc), 1);
      chk("pop1_full", 32'(reply_full), 0);
      rx_done = 1;
      step();
      rx_done = 0;
      #1;
      chk("pop2_rx_pf", 32'(rx_to_pf), 0);
      chk("pop2_rx_sc", 32'(rx_to_sc), 0);
      chk("pop2_perr", 32'(protocol_error), 0);

      // rx_done with nothing outstanding
      rx_done = 1;
      step();
      rx_done = 0;
      #1;
      chk("perr_set", 32'(protocol_error), 1);
      step(); step();
      chk("perr_sticky", 32'(protocol_error), 1);

      // reset in BUSY_PF with one outstanding reply
      pf_cmd_valid = 1; pf_reply_wanted = 1; pf_data = 2'b10;
      step();
      pf_cmd_valid = 0; pf_reply_wanted = 0; tx_data_next = 1;
      #1;
      chk("pre_rst_rx_pf", 32'(rx_to_pf), 1);
      chk("pre_rst_data", 32'(tx_data), 32'h2);
      reset = 1;
      step();
      reset = 0;
      #1;
      chk("post_rst_rx_pf", 32'(rx_to_pf), 0);
      chk("post_rst_data", 32'(tx_data), 0);
      chk("post_rst_pf_next", 32'(pf_data_next), 0);
      chk("post_rst_perr", 32'(protocol_error), 0);
      chk("post_rst_valid", 32'(tx_command_valid), 0);
      chk("post_rst_started", 32'(pf_cmd_started), 0);
      tx_data_next = 0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
